dmem_arbiter: RTL and testbench

Shares the pipeline's single data-memory port between the CPU MEM stage and a debug/loader port. The CPU normally owns the port. Debug gets in in two ways: idle cycles, and a starvation guard. A debug lock state lets debug own memory exclusively for multi-beat program/data loads. The block sits between the EX/MEM pipeline register outputs and `datamemory`. It drives a stall back to the pipeline whenever a CPU access is refused.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_starve_ctr.sv | 37 +++
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbiter ownership state: CPU-priority sharing or debug-exclusive lock
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Debug accesses are always full-word
    localparam logic [2:0] DBG_FUNC3 = 3'b010;

    // Width of the debug starvation wait counter
    localparam int WAIT_W = 4;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_ctr
//  Description : Saturating wait counter with clear and increment; counts the
//                cycles a pending debug request has been refused.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
    parameter int WIDTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max_cnt = WIDTH'(MAX_WAIT);

    logic [WIDTH-1:0] r_count;

    // Clear has priority; increment stops at the saturation value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max_cnt)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single data-memory port between the CPU MEM stage
//                and a debug/loader port. CPU has priority in RUN; debug gets
//                idle cycles, an optional starvation guard, and an exclusive
//                LOCK state for multi-beat loads.
//  Config      : DMEM_ARB_STARVE_GUARD_EN - enables the wait counter that
//                forces a debug request through after MAX_WAIT refusals.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_func3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_owns,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Reject out-of-range wait limits at elaboration
    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic                  w_cpu_acc;
    logic                  w_force;
    logic                  w_dbg_win;
    logic                  w_cpu_win;
    logic                  w_stall;

    assign w_cpu_acc = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [WAIT_W-1:0] w_wait_cnt;
    logic              w_wait_clr;
    logic              w_wait_inc;

    // Counter restarts whenever the request is served or withdrawn
    assign w_wait_clr = w_dbg_win | ~dbg_req;
    assign w_wait_inc = dbg_req & ~w_dbg_win;

    arb_starve_ctr #(
        .WIDTH    (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (w_wait_clr),
        .inc   (w_wait_inc),
        .count (w_wait_cnt)
    );

    // Counter is registered, so forcing never depends on this cycle's grant
    assign w_force = (w_wait_cnt == WAIT_W'(MAX_WAIT));
`else
    // Strict CPU priority: debug never preempts a CPU access in RUN
    assign w_force = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: LOCK entry waits until no read response is in flight
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (dbg_lock && !r_rvalid) w_state_nxt = LOCK;
            LOCK:    if (!dbg_lock)             w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Arbitration and memory-port muxing from state and request inputs
    always_comb begin
        w_dbg_win = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            RUN: begin
                w_dbg_win = dbg_req & (~w_cpu_acc | w_force);
                w_stall   = w_cpu_acc & w_dbg_win;
            end
            LOCK: begin
                w_dbg_win = dbg_req;
                w_stall   = w_cpu_acc;
            end
            default: begin
                w_dbg_win = 1'b0;
                w_stall   = 1'b0;
            end
        endcase
        w_cpu_win = w_cpu_acc & ~w_stall;

        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (w_dbg_win) begin
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = DBG_FUNC3;
        end else if (w_cpu_win) begin
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_func3 = cpu_func3;
        end
    end

    // Capture debug read data at the grant edge; valid for one cycle after
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_dbg_win & ~dbg_we;
            if (w_dbg_win && !dbg_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign dbg_gnt    = w_dbg_win;
    assign cpu_stall  = w_stall;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rvalid = r_rvalid;
    assign dbg_rdata  = r_rdata;
    assign dbg_owns   = (r_state == LOCK);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Randomised scoreboard bench for dmem_arbiter with a
//                behavioural ownership/memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int MW = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [2:0]    cpu_func3;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid, dbg_owns;
    logic [DW-1:0] dbg_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_owns(dbg_owns),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    // Environment data memory: combinational read, write at clock edge
    logic [DW-1:0] tb_mem  [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          mem_init;

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1<<AW); i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_wr) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic          gnt, stall, rd, wr, rvalid, owns;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rdata, cpu_rdata;
        logic [2:0]    f3;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit            m_lock, m_rv;
    int            m_wait;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dbg_gnt",    32'(dbg_gnt),    32'(e.gnt));
            chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
            chk("mem_rd",     32'(mem_rd),     32'(e.rd));
            chk("mem_wr",     32'(mem_wr),     32'(e.wr));
            chk("mem_addr",   32'(mem_addr),   32'(e.addr));
            chk("mem_wdata",  mem_wdata,       e.wdata);
            chk("mem_func3",  32'(mem_func3),  32'(e.f3));
            chk("cpu_rdata",  cpu_rdata,       e.cpu_rdata);
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.rvalid));
            chk("dbg_rdata",  dbg_rdata,       e.rdata);
            chk("dbg_owns",   32'(dbg_owns),   32'(e.owns));
        end
    end

    // One stimulus cycle: drive, predict, queue the prediction, advance model
    task automatic cyc(input bit rst, input bit crd, input bit cwr,
                       input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                       input logic [2:0] cf3, input bit dreq, input bit dwe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                       input bit dlock, output bit gnt_o);
        bit   acc, frc, g, s, rv_now;
        exp_t e;
        reset = rst; cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr;
        cpu_wdata = cwd; cpu_func3 = cf3; dbg_req = dreq; dbg_we = dwe;
        dbg_addr = daddr; dbg_wdata = dwd; dbg_lock = dlock;

        acc = crd | cwr;
        frc = GUARD && dreq && acc && !m_lock && (m_wait == MW);
        g   = dreq && (m_lock || !acc || frc);
        s   = acc && (m_lock || g);
        e.gnt = g; e.stall = s;
        e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.wdata = '0; e.f3 = 3'b000;
        if (g) begin
            e.rd = !dwe; e.wr = dwe; e.addr = daddr; e.wdata = dwd; e.f3 = 3'b010;
        end else if (acc && !s) begin
            e.rd = crd; e.wr = cwr; e.addr = caddr; e.wdata = cwd; e.f3 = cf3;
        end
        e.cpu_rdata = ref_mem[e.addr];
        e.rvalid = m_rv; e.rdata = m_rdata; e.owns = m_lock;
        exp_q.push_back(e);
        gnt_o = g;

        @(posedge clk);
        rv_now = m_rv;
        if (rst) begin
            m_lock = 0; m_rv = 0; m_wait = 0; m_rdata = '0;
        end else begin
            m_rv = g && !dwe;
            if (m_rv) m_rdata = ref_mem[daddr];
            if (!m_lock && dlock && !rv_now) m_lock = 1;
            else if (m_lock && !dlock)       m_lock = 0;
            if (!dreq || g) m_wait = 0;
            else if (m_wait < MW) m_wait++;
        end
        if (e.wr) ref_mem[e.addr] = e.wdata;
        #1;
    endtask

    initial begin
        bit            g, p_req, p_we, lk, rst;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wd;
        int            lk_left, op;

        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = $urandom;
        mem_init = 1'b1;
        reset = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        cpu_func3 = '0; dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        m_lock = 0; m_rv = 0; m_wait = 0; m_rdata = '0;

        // Reset state observed
        cyc(1, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 0, g);
        // CPU load, no debug
        cyc(0, 1, 0, 9'h010, '0, 3'b010, 0, 0, '0, '0, 0, g);
        // Debug write with CPU idle, then CPU reads it back
        cyc(0, 0, 0, '0, '0, 3'b000, 1, 1, 9'h020, 32'hDEADBEEF, 0, g);
        cyc(0, 1, 0, 9'h020, '0, 3'b010, 0, 0, '0, '0, 0, g);
        // CPU load held while debug read waits (forced only with guard)
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 9'h010, '0, 3'b010, !g || i == 0, 0, 9'h020, '0, 0, g);
        end
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 0, g);
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 0, g);
        // Lock with three back-to-back debug writes while CPU stores
        cyc(0, 0, 1, 9'h030, 32'h1111_0000, 3'b010, 0, 0, '0, '0, 1, g);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 9'h030, 32'h1111_0000, 3'b010, 1, 1, 9'(9'h040 + 4*i),
                32'hA5A5_0000 + 32'(i), 1, g);
        end
        cyc(0, 0, 1, 9'h030, 32'h1111_0000, 3'b010, 0, 0, '0, '0, 0, g);
        cyc(0, 0, 1, 9'h030, 32'h1111_0000, 3'b010, 0, 0, '0, '0, 0, g);
        // Lock request right after a debug read grant is deferred
        cyc(0, 0, 0, '0, '0, 3'b000, 1, 0, 9'h040, '0, 0, g);
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 1, g);
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 1, g);
        // Lock drops while debug still requests alongside a CPU load
        cyc(0, 1, 0, 9'h010, '0, 3'b010, 1, 0, 9'h044, '0, 0, g);
        cyc(0, 1, 0, 9'h010, '0, 3'b010, 0, 0, '0, '0, 0, g);
        // Reset coincident with a debug read grant discards the response
        cyc(1, 0, 0, '0, '0, 3'b000, 1, 0, 9'h020, '0, 0, g);
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 0, g);

        // Randomised traffic with held debug requests and lock bursts
        p_req = 0; p_we = 0; p_addr = '0; p_wd = '0; lk = 0; lk_left = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!p_req && $urandom_range(0, 2) == 0) begin
                p_req = 1; p_we = 1'($urandom_range(0, 1));
                p_addr = 9'($urandom_range(0, 15) * 4); p_wd = $urandom;
            end else if (p_req && $urandom_range(0, 19) == 0) begin
                p_req = 0;
            end
            if (lk_left == 0) begin
                lk = ($urandom_range(0, 7) == 0);
                lk_left = $urandom_range(1, 8);
            end else begin
                lk_left--;
            end
            op  = $urandom_range(0, 3);
            rst = ($urandom_range(0, 299) == 0);
            cyc(rst, op == 1 || op == 3, op == 2, 9'($urandom_range(0, 15) * 4),
                $urandom, 3'($urandom_range(0, 7)), p_req, p_we, p_addr, p_wd, lk, g);
            if (g || rst) p_req = 0;
        end
        cyc(0, 0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 0, g);

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
